// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard decoder.
// Holds byte codes, the frame FSM state enum and event-word field indices.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;

    localparam logic [7:0] PS2_DROP_00 = 8'h00;
    localparam logic [7:0] PS2_DROP_AA = 8'hAA;
    localparam logic [7:0] PS2_DROP_EE = 8'hEE;
    localparam logic [7:0] PS2_DROP_FA = 8'hFA;
    localparam logic [7:0] PS2_DROP_FE = 8'hFE;
    localparam logic [7:0] PS2_DROP_FF = 8'hFF;

    localparam int KEY_TOG = 10;
    localparam int KEY_PRS = 9;
    localparam int KEY_EXT = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    // Protocol bytes (ack, self-test, echo, resend, errors) never map to keys.
    function automatic logic ps2_is_drop(input logic [7:0] b);
        return (b == PS2_DROP_00) || (b == PS2_DROP_AA) ||
               (b == PS2_DROP_EE) || (b == PS2_DROP_FA) ||
               (b == PS2_DROP_FE) || (b == PS2_DROP_FF);
    endfunction

endpackage

// File: rtl/ps2_key_decoder_filter.sv
// ps2_line_filter: 2-flop synchroniser plus a stability filter for one line.
// Ports: clk_sys, reset_n (async low), i_line (raw pin), o_line (filtered).
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic i_line,
    output logic o_line
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          r_meta;
    logic          r_sync;
    logic          r_out;
    logic [CW-1:0] r_cnt;

    // Output flips only after FILTER_LEN consecutive samples disagree with it.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_out  <= 1'b1;
            r_cnt  <= '0;
        end else begin
            r_meta <= i_line;
            r_sync <= r_meta;
            if (r_sync == r_out) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
                r_out <= r_sync;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_line = r_out;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard deserialiser producing the 11-bit ps2_key event word.
// Ports: clk_sys, reset_n, ps2_clk, ps2_dat in; ps2_key, key_stb, frame_err out.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 96000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_dat,
    output logic [10:0] ps2_key,
    output logic        key_stb,
    output logic        frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic w_clk_f;
    logic w_dat_f;
    logic w_fall;
    logic w_tmo_hit;
    logic w_err;
    logic w_byte_vld;

    logic          r_clk_prev;
    ps2_state_t    r_state;
    ps2_state_t    w_next;
    logic [7:0]    r_shift;
    logic [2:0]    r_bitcnt;
    logic          r_par_ok;
    logic [TW-1:0] r_tmo;

    logic [10:0] r_key;
    logic        r_stb;
    logic        r_err;
    logic        r_ext;
    logic        r_rel;
    logic [2:0]  r_skip;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .i_line  (ps2_clk),
        .o_line  (w_clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .i_line  (ps2_dat),
        .o_line  (w_dat_f)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_prev <= w_clk_f;
        end
    end

    assign w_fall = r_clk_prev & ~w_clk_f;

    // An accepted edge in the terminal cycle takes priority over the timeout.
    assign w_tmo_hit = (r_state != IDLE) && !w_fall &&
                       (r_tmo == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_err      = 1'b0;
        w_byte_vld = 1'b0;
        if (w_tmo_hit) begin
            w_next = IDLE;
            w_err  = 1'b1;
        end else if (w_fall) begin
            unique case (r_state)
                IDLE: begin
                    if (!w_dat_f) begin
                        w_next = DATA;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                DATA: begin
                    if (r_bitcnt == 3'd7) begin
                        w_next = PARITY;
                    end
                end
                PARITY: begin
                    w_next = STOP;
                end
                STOP: begin
                    w_next = IDLE;
                    if (w_dat_f && r_par_ok) begin
                        w_byte_vld = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_par_ok <= 1'b0;
            r_tmo    <= '0;
        end else begin
            if (w_fall || (r_state == IDLE)) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + 1'b1;
            end
            if (w_fall) begin
                case (r_state)
                    IDLE: begin
                        r_bitcnt <= '0;
                    end
                    DATA: begin
                        r_shift  <= {w_dat_f, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 1'b1;
                    end
                    PARITY: begin
                        // Odd parity: data plus parity bit hold an odd count of ones.
                        r_par_ok <= ^{r_shift, w_dat_f};
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_key  <= '0;
            r_stb  <= 1'b0;
            r_err  <= 1'b0;
            r_ext  <= 1'b0;
            r_rel  <= 1'b0;
            r_skip <= '0;
        end else begin
            r_stb <= 1'b0;
            r_err <= w_err;
            if (w_byte_vld) begin
                // Pause emits a fixed 8-byte burst; swallow the 7 after E1.
                if (r_skip != 3'd0) begin
                    r_skip <= r_skip - 1'b1;
                end else if (r_shift == PS2_PAUSE) begin
                    r_skip <= 3'd7;
                end else if (r_shift == PS2_EXT) begin
                    r_ext <= 1'b1;
                end else if (r_shift == PS2_BRK) begin
                    r_rel <= 1'b1;
                end else if (ps2_is_drop(r_shift)) begin
                    r_ext <= 1'b0;
                    r_rel <= 1'b0;
                end else begin
                    r_key[KEY_TOG] <= ~r_key[KEY_TOG];
                    r_key[KEY_PRS] <= ~r_rel;
                    r_key[KEY_EXT] <= r_ext;
                    r_key[7:0]     <= r_shift;
                    r_stb          <= 1'b1;
                    r_ext          <= 1'b0;
                    r_rel          <= 1'b0;
                end
            end else if (w_err) begin
                r_ext <= 1'b0;
                r_rel <= 1'b0;
            end
        end
    end

    assign ps2_key   = r_key;
    assign key_stb   = r_stb;
    assign frame_err = r_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: frames, prefixes, errors, timeout,
// glitch rejection, pause sequence and mid-frame reset.
module tb_ps2_key_decoder;

    localparam int HALF = 16;
    localparam int TMO  = 3000;

    logic        clk_sys;
    logic        reset_n;
    logic        ps2_clk;
    logic        ps2_dat;
    logic [10:0] ps2_key;
    logic        key_stb;
    logic        frame_err;

    int total;
    int bad;
    int n_stb;
    int n_err;
    int n_both;
    int wait_cyc;
    bit seen;

    ps2_key_decoder #(
        .FILTER_LEN  (8),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .ps2_key   (ps2_key),
        .key_stb   (key_stb),
        .frame_err (frame_err)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        if (key_stb) n_stb++;
        if (frame_err) n_err++;
        if (key_stb && frame_err) n_both++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_sys);
    endtask

    task automatic send_bit(input logic b);
        ps2_dat = b;
        idle(HALF);
        ps2_clk = 1'b0;
        idle(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ flip);
        send_bit(1'b1);
        idle(4 * HALF);
    endtask

    task automatic clr_cnt;
        n_stb = 0;
        n_err = 0;
    endtask

    initial begin
        logic [7:0] pause_seq [8];
        total   = 0;
        bad     = 0;
        n_stb   = 0;
        n_err   = 0;
        n_both  = 0;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        reset_n = 1'b0;
        idle(5);
        reset_n = 1'b1;
        idle(20);

        chk("rst_key", ps2_key, 0);
        chk("rst_stb", key_stb, 0);
        chk("rst_err", frame_err, 0);

        clr_cnt();
        send_frame(8'h75, 1'b0);
        chk("k75_stb", n_stb, 1);
        chk("k75_err", n_err, 0);
        chk("k75_key", ps2_key, 11'h675);

        clr_cnt();
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h74, 1'b0);
        chk("e0f074_stb", n_stb, 1);
        chk("e0f074_key", ps2_key, 11'h174);

        clr_cnt();
        send_frame(8'hE0, 1'b0);
        send_frame(8'h29, 1'b1);
        chk("par_err", n_err, 1);
        chk("par_stb", n_stb, 0);
        chk("par_key", ps2_key, 11'h174);
        clr_cnt();
        send_frame(8'h29, 1'b0);
        chk("k29_stb", n_stb, 1);
        chk("k29_key", ps2_key, 11'h629);

        clr_cnt();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        seen     = 1'b0;
        wait_cyc = 0;
        while (!seen && wait_cyc < TMO + 200) begin
            @(negedge clk_sys);
            wait_cyc++;
            if (frame_err) seen = 1'b1;
        end
        chk("tmo_seen", seen, 1);
        chk("tmo_early", wait_cyc >= TMO - 20, 1);
        chk("tmo_late", wait_cyc <= TMO + 5, 1);
        idle(10);
        chk("tmo_nerr", n_err, 1);
        chk("tmo_nstb", n_stb, 0);
        clr_cnt();
        send_frame(8'h1C, 1'b0);
        chk("k1c_stb", n_stb, 1);
        chk("k1c_key", ps2_key, 11'h21C);

        clr_cnt();
        ps2_clk = 1'b0;
        idle(3);
        ps2_clk = 1'b1;
        idle(40);
        chk("glitch_err", n_err, 0);
        chk("glitch_stb", n_stb, 0);

        clr_cnt();
        send_frame(8'hFA, 1'b0);
        send_frame(8'hAA, 1'b0);
        chk("drop_stb", n_stb, 0);
        chk("drop_key", ps2_key, 11'h21C);
        send_frame(8'hE0, 1'b0);
        send_frame(8'hFA, 1'b0);
        send_frame(8'h12, 1'b0);
        chk("drop_ext_key", ps2_key, 11'h612);

        pause_seq[0] = 8'hE1;
        pause_seq[1] = 8'h14;
        pause_seq[2] = 8'h77;
        pause_seq[3] = 8'hE1;
        pause_seq[4] = 8'hF0;
        pause_seq[5] = 8'h14;
        pause_seq[6] = 8'hF0;
        pause_seq[7] = 8'h77;
        clr_cnt();
        for (int i = 0; i < 8; i++) send_frame(pause_seq[i], 1'b0);
        chk("pause_stb", n_stb, 0);
        chk("pause_err", n_err, 0);
        send_frame(8'h16, 1'b0);
        chk("k16_key", ps2_key, 11'h216);

        clr_cnt();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        reset_n = 1'b0;
        idle(3);
        chk("mrst_key", ps2_key, 0);
        reset_n = 1'b1;
        idle(20);
        chk("mrst_err", n_err, 0);
        chk("mrst_stb", n_stb, 0);
        send_frame(8'h75, 1'b0);
        chk("mrst_k75_stb", n_stb, 1);
        chk("mrst_k75_key", ps2_key, 11'h675);

        chk("never_both", n_both, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
